// File: rtl/nn_sched_pkg.sv
// Shared constants for the inference frame scheduler:
// state encoding and default widths.
`ifndef dataWidth
`define dataWidth 16
`endif

package nn_sched_pkg;

  localparam int DEF_DATA_WIDTH     = `dataWidth;
  localparam int DEF_NUM_INPUTS     = 784;
  localparam int DEF_RESULT_WIDTH   = 32;
  localparam int DEF_TIMEOUT_CYCLES = 65535;
  localparam int DEF_CNT_WIDTH      = 32;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FEED     = 2'd1;
  localparam logic [1:0] WAIT_RES = 2'd2;

endpackage

// File: rtl/nn_watchdog.sv
// Result watchdog: counts enabled cycles and flags expiry on
// the TIMEOUT_CYCLES-th one. TIMEOUT_CYCLES of 0 disables it.
module nn_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic s_axi_aclk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expire_o = 1'b0;
        end else begin : g_on
            assign expire_o = enable_i &&
                              (timer_q == TW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

    // Next timer value: hold at zero while cleared, count while enabled.
    always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
            timer_d = '0;
        end else if (enable_i && !expire_o) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Timer register.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/nn_inference_scheduler.sv
// Frame sequencer: admits one image per inference, waits for the
// maxFinder result, raises irq, with watchdog and abort/flush.
module nn_inference_scheduler
    import nn_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_INPUTS     = DEF_NUM_INPUTS,
    parameter int RESULT_WIDTH   = DEF_RESULT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                    s_axi_aclk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   s_axis_data,
    input  logic                    s_axis_valid,
    output logic                    s_axis_ready,
    output logic [DATA_WIDTH-1:0]   nn_x_data,
    output logic                    nn_x_valid,
    input  logic [RESULT_WIDTH-1:0] nn_result,
    input  logic                    nn_result_valid,
    output logic                    nn_flush,
    input  logic                    start,
    input  logic                    auto_mode,
    input  logic                    abort,
    input  logic                    irq_clear,
    output logic                    busy,
    output logic                    irq,
    output logic [RESULT_WIDTH-1:0] result_out,
    output logic                    timeout_err,
    output logic [CNT_WIDTH-1:0]    frame_count
);

    localparam int PCW = $clog2(NUM_INPUTS + 1);
    localparam logic [PCW-1:0] LAST_PIX = PCW'(NUM_INPUTS - 1);

    logic [1:0]              state_q, state_d;
    logic [PCW-1:0]          pix_q, pix_d;
    logic [DATA_WIDTH-1:0]   xdata_q, xdata_d;
    logic                    xvalid_q, xvalid_d;
    logic                    flush_q, flush_d;
    logic                    irq_q, irq_d;
    logic [RESULT_WIDTH-1:0] res_q, res_d;
    logic                    tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    wd_expire;

    nn_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .s_axi_aclk(s_axi_aclk),
        .reset     (reset),
        .clear_i   (state_q != WAIT_RES),
        .enable_i  (state_q == WAIT_RES),
        .expire_o  (wd_expire)
    );

    assign s_axis_ready = (state_q == FEED);
    assign busy         = (state_q != IDLE);
    assign nn_x_data    = xdata_q;
    assign nn_x_valid   = xvalid_q;
    assign nn_flush     = flush_q;
    assign irq          = irq_q;
    assign result_out   = res_q;
    assign timeout_err  = tmo_q;
    assign frame_count  = cnt_q;

    // Frame FSM: abort first, then per-state handshake/result/timeout.
    // irq_clear is applied before any set so a set on the same cycle wins.
    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        xdata_d  = xdata_q;
        xvalid_d = 1'b0;
        flush_d  = 1'b0;
        irq_d    = irq_clear ? 1'b0 : irq_q;
        res_d    = res_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;
        if (abort) begin
            state_d = IDLE;
            flush_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FEED;
                        pix_d   = '0;
                        tmo_d   = 1'b0;
                    end
                end
                FEED: begin
                    if (s_axis_valid) begin
                        xdata_d  = s_axis_data;
                        xvalid_d = 1'b1;
                        if (pix_q == LAST_PIX) begin
                            state_d = WAIT_RES;
                            pix_d   = '0;
                        end else begin
                            pix_d = pix_q + 1'b1;
                        end
                    end
                end
                WAIT_RES: begin
                    if (nn_result_valid) begin
                        res_d   = nn_result;
                        cnt_d   = cnt_q + 1'b1;
                        irq_d   = 1'b1;
                        pix_d   = '0;
                        state_d = auto_mode ? FEED : IDLE;
                    end else if (wd_expire) begin
                        tmo_d   = 1'b1;
                        irq_d   = 1'b1;
                        flush_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state_q  <= IDLE;
            pix_q    <= '0;
            xdata_q  <= '0;
            xvalid_q <= 1'b0;
            flush_q  <= 1'b0;
            irq_q    <= 1'b0;
            res_q    <= '0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            xdata_q  <= xdata_d;
            xvalid_q <= xvalid_d;
            flush_q  <= flush_d;
            irq_q    <= irq_d;
            res_q    <= res_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/nn_inference_scheduler.md
# nn_inference_scheduler

Frame-level sequencer sitting between the AXI-Stream pixel input and Layer 1 of the zyNet datapath. It admits exactly one image (NUM_INPUTS samples) per inference and back-pressures the stream until the maxFinder result returns. It then latches the result, raises the interrupt and either idles or auto-restarts. It also provides a watchdog timeout, a frame counter and an abort/flush path for the software-controlled AXI-Lite register block.

## Interface
- DATA_WIDTH, 16: sample width; equals the global dataWidth.
- NUM_INPUTS, 784: samples per frame; must be ≥1.
- RESULT_WIDTH, 32: width of the maxFinder result.
- TIMEOUT_CYCLES, 65535: maximum number of WAIT_RES cycles; 0 disables the watchdog.
- CNT_WIDTH, 32: frame counter width.

- s_axi_aclk  in  1  clock.
- reset  in  1  synchronous, active-high; clock s_axi_aclk.
- s_axis_data  in  DATA_WIDTH  pixel sample.
- s_axis_valid  in  1  sample valid.
- s_axis_ready  out  1  sample accept; asserted only in FEED.
- nn_x_data  out  DATA_WIDTH  sample to Layer 1, registered.
- nn_x_valid  out  1  sample valid to Layer 1, registered.
- nn_result  in  RESULT_WIDTH  maxFinder output.
- nn_result_valid  in  1  maxFinder output valid, single-cycle pulse.
- nn_flush  out  1  one-cycle pulse; the top level ORs it into the datapath reset.
- start  in  1  single-cycle pulse; begins one frame.
- auto_mode  in  1  level; when high, re-enters FEED after each completed frame.
- abort  in  1  pulse; cancels the current frame.
- irq_clear  in  1  pulse; clears irq.
- busy  out  1  high in FEED or WAIT_RES.
- irq  out  1  sticky; set when a frame completes or times out.
- result_out  out  RESULT_WIDTH  last valid result.
- timeout_err  out  1  sticky; set on watchdog expiry, cleared by start.
- frame_count  out  CNT_WIDTH  number of completed frames; wraps modulo 2^CNT_WIDTH.

## Operation
- **States:** IDLE, FEED, WAIT_RES.
- **IDLE**
  - start → FEED, pix_cnt=0, timeout_err cleared.
  - auto_mode alone does not start a frame.
- **FEED**
  - s_axis_ready=1 (combinational from state).
  - Each handshake: nn_x_data<=s_axis_data, nn_x_valid<=1, pix_cnt++.
  - No handshake: nn_x_valid<=0.
  - Handshake with pix_cnt==NUM_INPUTS-1 → WAIT_RES, watchdog timer=0.
- **WAIT_RES**
  - s_axis_ready=0; timer increments each cycle.
  - nn_result_valid → result_out<=nn_result, frame_count++, irq<=1; next state FEED if auto_mode else IDLE.
  - timer==TIMEOUT_CYCLES-1 with no result → timeout_err<=1, irq<=1, nn_flush pulse, → IDLE regardless of auto_mode.
- **abort** in any state → IDLE, nn_x_valid<=0, nn_flush pulse. Counters and result_out are unchanged. abort in IDLE still pulses nn_flush.
- **Simultaneous events**
  - result_valid on the same cycle as watchdog expiry: the result wins and no timeout is recorded.
  - abort has priority over every other event.
  - irq set and irq_clear on the same cycle: set wins.
  - start while busy: ignored.
- **Spurious input:** nn_result_valid outside WAIT_RES is ignored and nothing is latched.
- **Reset values:** all outputs 0, including s_axis_ready, nn_x_valid, nn_x_data, nn_flush, busy, irq, result_out, timeout_err and frame_count. State=IDLE. Reset mid-frame discards the frame; the datapath is cleared by the same reset.

## Timing
- start pulse at cycle t: s_axis_ready=1 from t+1.
- Input to datapath: latency 1 cycle from handshake to nn_x_valid.
- Last-sample handshake at cycle t: s_axis_ready=0 from t+1.
- Result pulse at cycle t: result_out, irq and frame_count are updated at t+1. With auto_mode, s_axis_ready=1 at t+1.
- Watchdog: expires on the TIMEOUT_CYCLES-th WAIT_RES cycle; nn_flush is high for exactly one cycle.
- Throughput: one sample per cycle when s_axis_valid is held high.

## Structure
- **Shared package `nn_sched_pkg`:** state encoding localparams (IDLE=2'd0, FEED=2'd1, WAIT_RES=2'd2) and default widths. DATA_WIDTH defaults from the global dataWidth define.
- **Sub-module `nn_watchdog`:** clear/enable inputs, expire output, parameterised by TIMEOUT_CYCLES. It contains the disable-at-0 logic.
- pix_cnt width is $clog2(NUM_INPUTS+1).

## Test plan
Bench parameters: NUM_INPUTS=4, TIMEOUT_CYCLES=20.

- **Basic frame:** reset, start, stream samples 1,2,3,4 back-to-back; result_valid with 0x7 after 10 cycles.
  - nn_x_data=1..4 on consecutive cycles, ready low after the 4th handshake.
  - result_out=7, frame_count=1, irq=1.
  - irq_clear → irq=0.
- **Gapped input:** valid toggling 1/0 during the same frame → exactly 4 nn_x_valid pulses. A 5th offered sample is not accepted (ready=0).
- **Auto mode:** auto_mode=1, two frames. Results 3 then 5 → frame_count=2, result_out=5, ready re-asserted the cycle after each result.
- **Timeout:** start, send 4 samples, no result.
  - 20 cycles later: timeout_err=1, irq=1, one nn_flush pulse, state IDLE even with auto_mode=1.
  - Next start clears timeout_err.
- **Abort and spurious result:** abort after 2 samples → ready=0, nn_flush pulse, frame_count unchanged. A result_valid while IDLE leaves result_out unchanged.
- **Collision cases:**
  - result_valid on cycle 20 of WAIT_RES → result latched, timeout_err=0.
  - irq_clear coinciding with completion → irq=1.
  - start while busy → no effect.
